// File: rtl/dfr_phase_sequencer.sv
// dfr_phase_sequencer
// Walks the reservoir datapath through the INIT, TRAIN and TEST phases. It issues
// one step request per reservoir step and tracks the step, sample and global
// sample indices. Phases with no work are skipped.

module dfr_phase_sequencer #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 Local_Reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_init_samples,
    input  logic [CNT_WIDTH-1:0] num_train_samples,
    input  logic [CNT_WIDTH-1:0] num_test_samples,
    input  logic [CNT_WIDTH-1:0] num_steps_per_sample,
    input  logic                 step_ack,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           phase,
    output logic                 step_req,
    output logic [CNT_WIDTH-1:0] sample_idx,
    output logic [CNT_WIDTH-1:0] step_idx,
    output logic [CNT_WIDTH-1:0] global_sample,
    output logic                 sample_first,
    output logic                 capture
);

    localparam int unsigned   CW   = CNT_WIDTH;
    localparam logic [CW-1:0] ZERO = CW'(0);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_TRAIN = 3'd2,
        ST_TEST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Copies of the configuration taken at start; the live inputs may change mid-run
    logic [CW-1:0] init_q;
    logic [CW-1:0] train_q;
    logic [CW-1:0] test_q;
    logic [CW-1:0] steps_q;

    logic          handshake;
    logic          last_step;
    logic          last_sample;
    logic [CW-1:0] cur_samples;

    // A phase is empty when it has no samples or when a sample has no steps
    logic   init_ne_in;
    logic   train_ne_in;
    logic   test_ne_in;
    logic   train_ne_q;
    logic   test_ne_q;
    state_t first_phase;
    state_t after_init;
    state_t after_train;

    assign handshake = step_req & step_ack;

    assign init_ne_in  = (num_init_samples  != ZERO) && (num_steps_per_sample != ZERO);
    assign train_ne_in = (num_train_samples != ZERO) && (num_steps_per_sample != ZERO);
    assign test_ne_in  = (num_test_samples  != ZERO) && (num_steps_per_sample != ZERO);
    assign train_ne_q  = (train_q != ZERO) && (steps_q != ZERO);
    assign test_ne_q   = (test_q  != ZERO) && (steps_q != ZERO);

    // Pick the first phase that has work, checked against the live inputs at start
    always_comb begin
        first_phase = ST_DONE;
        if (test_ne_in) begin
            first_phase = ST_TEST;
        end
        if (train_ne_in) begin
            first_phase = ST_TRAIN;
        end
        if (init_ne_in) begin
            first_phase = ST_INIT;
        end
    end

    // Pick the phase that follows INIT or TRAIN, using the latched counts
    always_comb begin
        after_train = test_ne_q ? ST_TEST : ST_DONE;
        after_init  = train_ne_q ? ST_TRAIN : after_train;
    end

    // Sample count of the phase that is currently running
    always_comb begin
        cur_samples = ZERO;
        case (state)
            ST_INIT:  cur_samples = init_q;
            ST_TRAIN: cur_samples = train_q;
            ST_TEST:  cur_samples = test_q;
            default:  cur_samples = ZERO;
        endcase
    end

    // Equality compares avoid the overflow that a compare with steps/samples+1 would have
    assign last_step   = (step_idx   == (steps_q - ONE));
    assign last_sample = (sample_idx == (cur_samples - ONE));

    // State register
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over a coincident end of phase
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = first_phase;
                end
            end
            ST_INIT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (handshake && last_step && last_sample) begin
                    state_nxt = after_init;
                end
            end
            ST_TRAIN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (handshake && last_step && last_sample) begin
                    state_nxt = after_train;
                end
            end
            ST_TEST: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (handshake && last_step && last_sample) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        phase        = 2'd0;
        step_req     = 1'b0;
        sample_first = 1'b0;
        capture      = 1'b0;
        case (state)
            ST_INIT: begin
                busy         = 1'b1;
                phase        = 2'd1;
                step_req     = 1'b1;
                sample_first = (step_idx == ZERO);
            end
            ST_TRAIN: begin
                busy         = 1'b1;
                phase        = 2'd2;
                step_req     = 1'b1;
                sample_first = (step_idx == ZERO);
                capture      = last_step;
            end
            ST_TEST: begin
                busy         = 1'b1;
                phase        = 2'd3;
                step_req     = 1'b1;
                sample_first = (step_idx == ZERO);
                capture      = last_step;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Latch the configuration when a sequence is launched
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            init_q  <= ZERO;
            train_q <= ZERO;
            test_q  <= ZERO;
            steps_q <= ZERO;
        end else if ((state == ST_IDLE) && start) begin
            init_q  <= num_init_samples;
            train_q <= num_train_samples;
            test_q  <= num_test_samples;
            steps_q <= num_steps_per_sample;
        end
    end

    // Step/sample/global counters: cleared around IDLE, advanced on each handshake
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            step_idx      <= ZERO;
            sample_idx    <= ZERO;
            global_sample <= ZERO;
        end else if ((state == ST_IDLE) || (state_nxt == ST_IDLE)) begin
            step_idx      <= ZERO;
            sample_idx    <= ZERO;
            global_sample <= ZERO;
        end else if (handshake) begin
            if (last_step) begin
                step_idx      <= ZERO;
                global_sample <= global_sample + ONE;
                sample_idx    <= last_sample ? ZERO : (sample_idx + ONE);
            end else begin
                step_idx <= step_idx + ONE;
            end
        end
    end

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Self-checking bench for dfr_phase_sequencer. The reference model flattens a run into
// a linear list of steps and computes each step's phase, sample and step index
// arithmetically from its position in that list.

module tb_dfr_phase_sequencer;

    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          Local_Reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_init_samples;
    logic [CW-1:0] num_train_samples;
    logic [CW-1:0] num_test_samples;
    logic [CW-1:0] num_steps_per_sample;
    logic          step_ack;
    logic          busy;
    logic          done;
    logic [1:0]    phase;
    logic          step_req;
    logic [CW-1:0] sample_idx;
    logic [CW-1:0] step_idx;
    logic [CW-1:0] global_sample;
    logic          sample_first;
    logic          capture;

    dfr_phase_sequencer #(.CNT_WIDTH(CW)) dut (
        .S_AXI_ACLK           (clk),
        .Local_Reset          (Local_Reset),
        .start                (start),
        .abort                (abort),
        .num_init_samples     (num_init_samples),
        .num_train_samples    (num_train_samples),
        .num_test_samples     (num_test_samples),
        .num_steps_per_sample (num_steps_per_sample),
        .step_ack             (step_ack),
        .busy                 (busy),
        .done                 (done),
        .phase                (phase),
        .step_req             (step_req),
        .sample_idx           (sample_idx),
        .step_idx             (step_idx),
        .global_sample        (global_sample),
        .sample_first         (sample_first),
        .capture              (capture)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // model: 0 idle, 1 running, 2 done
    int              m_mode = 0;
    longint unsigned m_n [1:3];
    longint unsigned m_steps;
    longint unsigned m_pos;
    longint unsigned m_total;

    // per-run observations, k = clock edges since the start edge
    int run_cyc = 0;
    int n_req, n_cap, n_hs, n_done, done_at, busy_low_at, first_req_phase;
    int ph_cnt [0:3];
    longint unsigned max_glob, first_req_glob;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Locate list position pos within the phase sequence
    function automatic void item_at(input longint unsigned pos, output int ph,
                                    output longint unsigned smp, output longint unsigned stp,
                                    output longint unsigned glob);
        longint unsigned p;
        longint unsigned base;
        longint unsigned sz;
        p = pos; base = 0;
        ph = 0; smp = 0; stp = 0; glob = 0;
        for (int k = 1; k <= 3; k++) begin
            sz = (m_steps == 0) ? 64'd0 : m_n[k] * m_steps;
            if (ph == 0) begin
                if (p < sz) begin
                    ph   = k;
                    smp  = p / m_steps;
                    stp  = p % m_steps;
                    glob = base + smp;
                end else begin
                    p    = p - sz;
                    base = base + m_n[k];
                end
            end
        end
    endfunction

    task automatic compare();
        int ph;
        longint unsigned smp, stp, glob;
        chk("busy",     64'(busy),     64'(m_mode != 0));
        chk("done",     64'(done),     64'(m_mode == 2));
        chk("step_req", 64'(step_req), 64'(m_mode == 1));
        if (m_mode == 1) begin
            item_at(m_pos, ph, smp, stp, glob);
            chk("phase",         64'(phase),         64'(ph));
            chk("sample_idx",    64'(sample_idx),    64'(CW'(smp)));
            chk("step_idx",      64'(step_idx),      64'(CW'(stp)));
            chk("global_sample", 64'(global_sample), 64'(CW'(glob)));
            chk("sample_first",  64'(sample_first),  64'(stp == 0));
            chk("capture",       64'(capture),       64'((ph >= 2) && (stp == m_steps - 1)));
        end else begin
            chk("phase",        64'(phase),        64'd0);
            chk("sample_first", 64'(sample_first), 64'd0);
            chk("capture",      64'(capture),      64'd0);
            if (m_mode == 0) begin
                chk("sample_idx",    64'(sample_idx),    64'd0);
                chk("step_idx",      64'(step_idx),      64'd0);
                chk("global_sample", 64'(global_sample), 64'd0);
            end
        end
    endtask

    // One clock: entered and left at a falling edge
    task automatic tick(input logic st, input logic ab, input logic ack);
        bit launched;
        launched = 1'b0;
        start = st; abort = ab; step_ack = ack;
        compare();
        if (run_cyc > 0) begin
            if (step_req) begin
                if (n_req == 0) begin
                    first_req_phase = int'(phase);
                    first_req_glob  = 64'(global_sample);
                end
                n_req++;
                ph_cnt[phase]++;
                if (64'(global_sample) > max_glob) max_glob = 64'(global_sample);
                if (capture) n_cap++;
                if (ack) n_hs++;
            end
            if (done) begin
                n_done++;
                done_at = run_cyc;
            end
            if (!busy && busy_low_at == 0) busy_low_at = run_cyc;
        end
        case (m_mode)
            0: if (st) begin
                m_n[1]  = 64'(num_init_samples);
                m_n[2]  = 64'(num_train_samples);
                m_n[3]  = 64'(num_test_samples);
                m_steps = 64'(num_steps_per_sample);
                m_total = (m_n[1] + m_n[2] + m_n[3]) * m_steps;
                m_pos   = 0;
                m_mode  = (m_total == 0) ? 2 : 1;
                n_req = 0; n_cap = 0; n_hs = 0; n_done = 0; done_at = 0; busy_low_at = 0;
                first_req_phase = 0; first_req_glob = 0; max_glob = 0;
                for (int k = 0; k < 4; k++) ph_cnt[k] = 0;
                run_cyc  = 1;
                launched = 1'b1;
            end
            1: begin
                if (ab) begin
                    m_mode = 0;
                end else if (ack) begin
                    m_pos++;
                    if (m_pos == m_total) m_mode = 2;
                end
            end
            default: m_mode = 0;
        endcase
        if (!launched && run_cyc > 0) run_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        Local_Reset = 1'b1; start = 1'b0; abort = 1'b0;
        #1;
        chk("rst_busy",     64'(busy),          64'd0);
        chk("rst_done",     64'(done),          64'd0);
        chk("rst_phase",    64'(phase),         64'd0);
        chk("rst_step_req", 64'(step_req),      64'd0);
        chk("rst_idx",      64'(step_idx),      64'd0);
        chk("rst_sample",   64'(sample_idx),    64'd0);
        chk("rst_global",   64'(global_sample), 64'd0);
        m_mode  = 0;
        run_cyc = 0;
        @(posedge clk);
        @(negedge clk);
        Local_Reset = 1'b0;
    endtask

    task automatic run(input longint unsigned ni, input longint unsigned ntr,
                       input longint unsigned nte, input longint unsigned ns,
                       input int ack_pct, input int abort_hs, input int restart_k,
                       input bit chg, input int rst_k);
        int   guard;
        logic ack, ab;
        guard = 0;
        num_init_samples     = CW'(ni);
        num_train_samples    = CW'(ntr);
        num_test_samples     = CW'(nte);
        num_steps_per_sample = CW'(ns);
        tick(1'b1, 1'b0, 1'b1);
        while (m_mode != 0 && guard < 3000) begin
            guard++;
            ack = ($urandom_range(99) < 32'(ack_pct));
            ab  = (abort_hs > 0) && (n_hs == abort_hs - 1) && step_req && ack;
            if (chg) begin
                num_init_samples     = CW'($urandom_range(3));
                num_train_samples    = CW'($urandom_range(3));
                num_test_samples     = CW'($urandom_range(3));
                num_steps_per_sample = CW'($urandom_range(4));
            end
            if (rst_k > 0 && run_cyc == rst_k) mid_reset();
            else tick(restart_k == run_cyc, ab, ack);
        end
        chk("run_terminates", 64'(m_mode), 64'd0);
        m_mode = 0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Local_Reset = 1'b1;
        start = 1'b0; abort = 1'b0; step_ack = 1'b0;
        num_init_samples = '0; num_train_samples = '0;
        num_test_samples = '0; num_steps_per_sample = '0;
        repeat (3) @(negedge clk);
        compare();
        Local_Reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0);

        // 2/3/1 samples, 4 steps, ack always high
        run(2, 3, 1, 4, 100, 0, -1, 1'b0, 0);
        chk("p1_req_cycles", 64'(n_req), 64'd24);
        chk("p1_init_cyc",   64'(ph_cnt[1]), 64'd8);
        chk("p1_train_cyc",  64'(ph_cnt[2]), 64'd12);
        chk("p1_test_cyc",   64'(ph_cnt[3]), 64'd4);
        chk("p1_captures",   64'(n_cap), 64'd4);
        chk("p1_max_global", max_glob, 64'd5);
        chk("p1_done_at",    64'(done_at), 64'd25);
        chk("p1_done_count", 64'(n_done), 64'd1);
        chk("p1_busy_low",   64'(busy_low_at), 64'd26);

        // INIT skipped
        run(0, 2, 0, 3, 100, 0, -1, 1'b0, 0);
        chk("p2_first_phase", 64'(first_req_phase), 64'd2);
        chk("p2_handshakes",  64'(n_hs), 64'd6);
        chk("p2_done_count",  64'(n_done), 64'd1);

        // everything empty
        run(0, 0, 0, 4, 100, 0, -1, 1'b0, 0);
        chk("p3_done_at", 64'(done_at), 64'd1);
        chk("p3_req",     64'(n_req), 64'd0);
        chk("p3_done_n",  64'(n_done), 64'd1);
        run(5, 5, 5, 0, 100, 0, -1, 1'b0, 0);
        chk("p3b_done_at", 64'(done_at), 64'd1);
        chk("p3b_req",     64'(n_req), 64'd0);

        // stalled acks with an ignored restart
        run(0, 2, 0, 5, 50, 0, 4, 1'b0, 0);
        chk("p4_handshakes", 64'(n_hs), 64'd10);
        chk("p4_done_count", 64'(n_done), 64'd1);

        // abort on handshake 7 of 20, then a clean restart
        run(0, 4, 0, 5, 100, 7, -1, 1'b0, 0);
        chk("p5_done_count", 64'(n_done), 64'd0);
        chk("p5_handshakes", 64'(n_hs), 64'd7);
        chk("p5_busy_low",   64'(busy_low_at), 64'd8);
        run(0, 4, 0, 5, 100, 0, -1, 1'b0, 0);
        chk("p5_restart_glob", first_req_glob, 64'd0);
        chk("p5_restart_hs",   64'(n_hs), 64'd20);

        // reset inside TRAIN with live count changes
        run(1, 3, 1, 4, 100, 0, -1, 1'b1, 8);
        chk("p6_done_count", 64'(n_done), 64'd0);
        run(1, 2, 1, 3, 70, 0, -1, 1'b1, 0);
        chk("p6_hs_after", 64'(n_hs), 64'd12);

        // wide counts
        run(0, 64'hFFFF_FFFF, 0, 2, 100, 9, -1, 1'b0, 0);
        run(0, 0, 1, 64'hFFFF_FFFF, 100, 3, -1, 1'b0, 0);

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            run(64'($urandom_range(3)), 64'($urandom_range(3)), 64'($urandom_range(3)),
                64'($urandom_range(4)), int'($urandom_range(100, 30)),
                ($urandom_range(3) == 0) ? int'($urandom_range(12, 1)) : 0,
                ($urandom_range(2) == 0) ? int'($urandom_range(6, 2)) : -1,
                1'($urandom_range(1)),
                ($urandom_range(5) == 0) ? int'($urandom_range(10, 2)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
